// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// baud divider helper used by both the receive and transmit halves.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } uart_rx_state_t;

  // Clocks per oversample tick; truncating division, caller keeps it >= 1.
  function automatic int uart_div(input int clk, input int baud);
    return clk / (baud * UART_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one Tick every DIV clocks. Restart realigns the
// tick phase so the first Tick comes DIV clocks after the restart cycle.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Restart,
  output logic Tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Free-running modulo-DIV count, forced back to zero on Restart.
  always_comb begin
    cnt_d = cnt_q;
    if (Restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, framing-error
// and overrun flags, and a four-phase Rx_Ready/Rx_Ack delivery handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      Rx,
  output logic [UART_DATA_BITS-1:0] Rx_Data,
  output logic                      Rx_Ready,
  input  logic                      Rx_Ack,
  output logic                      Rx_Overrun,
  output logic                      Rx_Frame_Error
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int TW  = $clog2(UART_OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(UART_OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

  logic                      sync1_q, sync2_q, prev_q;
  logic [2:0]                primed_q;
  uart_rx_state_t            state_q, state_d;
  logic [TW-1:0]             tickCnt_q, tickCnt_d;
  logic [BW-1:0]             bitCnt_q, bitCnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      ready_q, ready_d;
  logic                      overrun_q, overrun_d;
  logic                      frameErr_q, frameErr_d;
  logic                      restart, tick, deliver, fallEdge;

  uart_baud_tick #(.DIV(DIV)) uBaudTick (
    .Clk     (Clk),
    .nReset  (nReset),
    .Restart (restart),
    .Tick    (tick)
  );

  // Two-flop synchronizer plus edge-detect history; primed_q keeps reset
  // values of the flops from masquerading as a real high-to-low transition.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      primed_q <= '0;
    end else begin
      sync1_q  <= Rx;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      primed_q <= {primed_q[1:0], 1'b1};
    end
  end

  assign fallEdge = primed_q[2] && prev_q && !sync2_q;

  // Frame FSM, shift register and delivery handshake next-state logic.
  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ready_d    = ready_q;
    overrun_d  = overrun_q;
    frameErr_d = 1'b0;
    restart    = 1'b0;
    deliver    = 1'b0;

    if (ready_q && Rx_Ack) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        if (fallEdge) begin
          state_d   = RX_START;
          tickCnt_d = '0;
          restart   = 1'b1;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tickCnt_q == HALF_LAST) begin
            tickCnt_d = '0;
            bitCnt_d  = '0;
            state_d   = sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            shift_d   = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
            bitCnt_d  = bitCnt_q + 1'b1;
            if (bitCnt_q == BIT_LAST) begin
              state_d = RX_STOP;
            end
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            if (sync2_q) begin
              deliver = 1'b1;
              state_d = RX_IDLE;
            end else begin
              frameErr_d = 1'b1;
              state_d    = RX_BREAK;
            end
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
      end
      RX_BREAK: begin
        if (sync2_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Judged against pre-edge handshake state, so a byte landing while the
    // consumer is still acknowledging is dropped and flagged as an overrun.
    if (deliver) begin
      if (!ready_q && !Rx_Ack) begin
        data_d  = shift_q;
        ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= RX_IDLE;
      tickCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign Rx_Data        = data_q;
  assign Rx_Ready       = ready_q;
  assign Rx_Overrun     = overrun_q;
  assign Rx_Frame_Error = frameErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit (DIV=1). A frame-level
// model predicts every output each cycle; directed checks pin key timings.
module tb_uart_rx;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       Rx;
  logic       Rx_Ack;
  logic [7:0] Rx_Data;
  logic       Rx_Ready;
  logic       Rx_Overrun;
  logic       Rx_Frame_Error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit autoAck = 1'b0;

  typedef struct {
    int         at;
    bit         fe;
    logic [7:0] b;
  } ev_t;

  ev_t        evQ[$];
  logic       mReady, mOv, mFe, nr, no;
  logic [7:0] mData;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .Clk            (Clk),
    .nReset         (nReset),
    .Rx             (Rx),
    .Rx_Data        (Rx_Data),
    .Rx_Ready       (Rx_Ready),
    .Rx_Ack         (Rx_Ack),
    .Rx_Overrun     (Rx_Overrun),
    .Rx_Frame_Error (Rx_Frame_Error)
  );

  // 10-unit clock period.
  always #5 Clk = ~Clk;

  // Frame-level model: each sent frame resolves 155 clocks after its start
  // edge into a delivery, an overrun or a framing-error pulse.
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      mReady = 1'b0;
      mOv    = 1'b0;
      mFe    = 1'b0;
      mData  = 8'h00;
      evQ.delete();
    end else begin
      cyc = cyc + 1;
      nr  = mReady;
      no  = mOv;
      mFe = 1'b0;
      if (mReady && Rx_Ack) begin
        nr = 1'b0;
        no = 1'b0;
      end
      if (evQ.size() > 0 && evQ[0].at == cyc) begin
        if (evQ[0].fe) begin
          mFe = 1'b1;
        end else if (!mReady && !Rx_Ack) begin
          mData = evQ[0].b;
          nr    = 1'b1;
        end else begin
          no = 1'b1;
        end
        void'(evQ.pop_front());
      end
      mReady = nr;
      mOv    = no;
    end
  end

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge Clk) begin
    checks++;
    if (Rx_Ready !== mReady || Rx_Data !== mData ||
        Rx_Overrun !== mOv || Rx_Frame_Error !== mFe) begin
      errors++;
      $display("[TB] FAIL model-compare cyc=%0d got rdy=%0b data=%02h ov=%0b fe=%0b expected rdy=%0b data=%02h ov=%0b fe=%0b",
               cyc, Rx_Ready, Rx_Data, Rx_Overrun, Rx_Frame_Error,
               mReady, mData, mOv, mFe);
    end
  end

  // Consumer that acknowledges a few clocks after Rx_Ready, bounded wait.
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (autoAck && Rx_Ready && !Rx_Ack) begin
        repeat (4) @(posedge Clk);
        #1 Rx_Ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(posedge Clk); #1;
          if (!Rx_Ready) break;
        end
        Rx_Ack = 1'b0;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    repeat (60000) @(posedge Clk);
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one 8N1 frame one clock at a time; stopLow>0 holds the stop bit low
  // that many clocks, cut>0 abandons the frame after that many clocks.
  task automatic applyStimulus(input logic [7:0] b, input int stopLow, input int cut);
    int  total;
    int  n;
    ev_t ev;
    total = (stopLow > 0) ? 144 + stopLow + 16 : 160;
    if (cut > 0) total = cut;
    @(posedge Clk); #1;
    n = cyc;
    if (cut == 0) begin
      ev.at = n + 155;
      ev.fe = (stopLow > 0);
      ev.b  = b;
      evQ.push_back(ev);
    end
    for (int t = 0; t < total; t++) begin
      if (t < 16)                 Rx = 1'b0;
      else if (t < 144)           Rx = b[(t - 16) / 16];
      else if (t < 144 + stopLow) Rx = 1'b0;
      else                        Rx = 1'b1;
      @(posedge Clk); #1;
    end
  endtask

  // Manual acknowledge, checking Ready/Overrun just before and after the edge.
  task automatic ackByHand(input string name, input int expOv);
    @(posedge Clk); #1 Rx_Ack = 1'b1;
    @(negedge Clk);
    checkOutput({name, "-ready-before-fall"}, int'(Rx_Ready), 1);
    checkOutput({name, "-ov-before-fall"}, int'(Rx_Overrun), expOv);
    @(negedge Clk);
    checkOutput({name, "-ready-after-fall"}, int'(Rx_Ready), 0);
    checkOutput({name, "-ov-after-fall"}, int'(Rx_Overrun), 0);
    @(posedge Clk); #1 Rx_Ack = 1'b0;
  endtask

  int feCount;
  int readyCount;

  initial begin
    nReset = 1'b0;
    Rx     = 1'b1;
    Rx_Ack = 1'b0;
    #2;
    checkOutput("reset-ready", int'(Rx_Ready), 0);
    checkOutput("reset-data", int'(Rx_Data), 8'h00);
    checkOutput("reset-ov", int'(Rx_Overrun), 0);
    checkOutput("reset-fe", int'(Rx_Frame_Error), 0);
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;
    repeat (10) @(posedge Clk);

    // 8'h41 with no ack: Ready exactly at clock 155, then held.
    fork
      applyStimulus(8'h41, 0, 0);
      begin
        @(posedge Clk); #1;
        repeat (155) @(negedge Clk);
        checkOutput("ready-at-154", int'(Rx_Ready), 0);
        @(negedge Clk);
        checkOutput("ready-at-155", int'(Rx_Ready), 1);
        checkOutput("data-41", int'(Rx_Data), 8'h41);
      end
    join
    repeat (100) @(negedge Clk);
    checkOutput("ready-held", int'(Rx_Ready), 1);
    ackByHand("ack41", 0);
    repeat (5) @(posedge Clk);

    // Back-to-back 8'h55 / 8'hAA with a prompt consumer.
    autoAck = 1'b1;
    applyStimulus(8'h55, 0, 0);
    applyStimulus(8'hAA, 0, 0);
    repeat (40) @(posedge Clk);
    checkOutput("data-aa", int'(Rx_Data), 8'hAA);
    checkOutput("b2b-ov", int'(Rx_Overrun), 0);
    autoAck = 1'b0;
    repeat (20) @(posedge Clk);

    // Overrun: 8'h01 unacknowledged, then 8'hFF is dropped.
    applyStimulus(8'h01, 0, 0);
    applyStimulus(8'hFF, 0, 0);
    repeat (5) @(negedge Clk);
    checkOutput("overrun-data", int'(Rx_Data), 8'h01);
    checkOutput("overrun-flag", int'(Rx_Overrun), 1);
    ackByHand("ackOv", 1);
    repeat (5) @(posedge Clk);

    // Framing error on 8'h3C, then a clean 8'h5A.
    autoAck = 1'b1;
    fork
      applyStimulus(8'h3C, 40, 0);
      begin
        feCount    = 0;
        readyCount = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge Clk);
          if (Rx_Frame_Error) feCount++;
          if (Rx_Ready) readyCount++;
        end
      end
    join
    checkOutput("fe-pulse-count", feCount, 1);
    checkOutput("fe-no-ready", readyCount, 0);
    applyStimulus(8'h5A, 0, 0);
    repeat (30) @(posedge Clk);
    checkOutput("data-5a", int'(Rx_Data), 8'h5A);

    // 4-clock glitch on idle line, then 8'h7E.
    @(posedge Clk); #1 Rx = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Rx = 1'b1;
    repeat (200) @(posedge Clk);
    checkOutput("glitch-ready", int'(Rx_Ready), 0);
    applyStimulus(8'h7E, 0, 0);
    repeat (30) @(posedge Clk);
    checkOutput("data-7e", int'(Rx_Data), 8'h7E);
    autoAck = 1'b0;
    repeat (20) @(posedge Clk);

    // Reset during bit 4 with a byte pending, released while the line is low.
    applyStimulus(8'h99, 0, 0);
    applyStimulus(8'hC3, 0, 88);
    #3 nReset = 1'b0;
    #1;
    checkOutput("async-reset-ready", int'(Rx_Ready), 0);
    checkOutput("async-reset-data", int'(Rx_Data), 8'h00);
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;
    repeat (9) @(posedge Clk);
    #1 Rx = 1'b1;
    repeat (10) @(posedge Clk);
    applyStimulus(8'hC3, 0, 0);
    repeat (20) @(negedge Clk);
    checkOutput("post-reset-ready", int'(Rx_Ready), 1);
    checkOutput("post-reset-data", int'(Rx_Data), 8'hC3);
    ackByHand("ackC3", 0);
    repeat (10) @(posedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
